// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: op codes and FSM states.
package shift_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ROL = 2'b00;
    localparam op_t OP_SLL = 2'b01;
    localparam op_t OP_SRA = 2'b10;
    localparam op_t OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_stage.sv
// Single combinational shift stage with a run-time amount; the sequencer reuses it
// once per clock with a halving amount.
module shift_stage_var
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    input  op_t              op,
    input  logic [AMT_W-1:0] amt,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    logic [2*WIDTH-1:0]        doubled;
    logic signed [WIDTH-1:0]   in_signed;

    // Apply the selected shift by amt when enabled; a disabled stage passes the operand through.
    always_comb begin
        doubled   = {in, in} << amt;
        in_signed = $signed(in);
        out       = in;
        if (en) begin
            case (op)
                OP_ROL:  out = doubled[2*WIDTH-1:WIDTH];
                OP_SLL:  out = in << amt;
                OP_SRA:  out = $unsigned(in_signed >>> amt);
                OP_SRL:  out = in >> amt;
                default: out = in;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts one request per handshake, walks the shared
// shift stage through amounts WIDTH/2 .. 1 (one per clock), then presents the result.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [CNT_W-1:0] in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int               STEP_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0]  FIRST_AMT = CNT_W'(WIDTH / 2);

    state_t              state;
    state_t              state_next;
    logic [STEP_W-1:0]   step;
    logic [WIDTH-1:0]    acc;
    op_t                 op_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    stage_amt;
    logic                stage_en;
    logic [WIDTH-1:0]    stage_out;
    logic                accept;

    // Step k shifts by WIDTH>>(k+1) and is gated by count bit CNT_W-1-k (MSB first).
    assign stage_amt = FIRST_AMT >> step;
    assign stage_en  = cnt_reg[LAST_STEP - step];
    assign accept    = in_valid && in_ready;

    shift_stage_var #(
        .WIDTH (WIDTH),
        .AMT_W (CNT_W)
    ) u_stage (
        .in  (acc),
        .op  (op_reg),
        .amt (stage_amt),
        .en  (stage_en),
        .out (stage_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake logic; in_ready is the only combinational input-to-output path.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (step == LAST_STEP) state_next = ST_DONE;
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) state_next = in_valid ? ST_SHIFT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand/op/count capture on accept, then one registered stage per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            op_reg  <= OP_ROL;
            cnt_reg <= '0;
            step    <= '0;
        end else if (accept) begin
            acc     <= in_data;
            op_reg  <= in_op;
            cnt_reg <= in_cnt;
            step    <= '0;
        end else if (state == ST_SHIFT) begin
            acc  <= stage_out;
            step <= step + 1'b1;
        end
    end

    assign out_valid = (state == ST_DONE);
    assign out_data  = acc;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases, backpressure, async reset
// mid-operation, and a randomized run against a whole-shift reference model.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_op;
    logic [3:0]  in_cnt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    shift_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Whole shift by c in one step, straight from the op definitions.
    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                              input logic [3:0] c);
        logic signed [15:0] sd;
        sd = d;
        case (op)
            2'b00:   return (d << c) | (d >> (16 - c));
            2'b01:   return d << c;
            2'b10:   return sd >>> c;
            default: return d >> c;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE; checks exact 4-cycle latency and the result, then drains it.
    task automatic run_directed(input string tag, input logic [1:0] op, input logic [15:0] d,
                                input logic [3:0] c, input logic [15:0] exp);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_cnt    = c;
        out_ready = 1'b0;
        #1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        tick;
        in_valid = 1'b0;
        in_op    = ~op;
        in_data  = ~d;
        in_cnt   = ~c;
        check({tag, "_busy"}, busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_early_valid"}, out_valid, 1'b0);
            tick;
        end
        check({tag, "_early_valid"}, out_valid, 1'b0);
        tick;
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_model"}, out_data, ref_shift(op, d, c));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_drained"}, out_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    int          cyc;
    int          acc_cyc;
    int          nreq;
    bit          pending;
    bit          prev_valid;
    bit          prev_hold;
    logic [15:0] exp_data;
    logic [15:0] prev_data;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        in_cnt    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 16'h0000);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick;

        run_directed("rol_8001", 2'b00, 16'h8001, 4'd4, 16'h0018);
        run_directed("sll_8001", 2'b01, 16'h8001, 4'd4, 16'h0010);
        run_directed("srl_8000", 2'b11, 16'h8000, 4'd15, 16'h0001);
        run_directed("sra_8000", 2'b10, 16'h8000, 4'd15, 16'hFFFF);
        run_directed("sra_7ff0", 2'b10, 16'h7FF0, 4'd4, 16'h07FF);
        run_directed("cnt0_rol", 2'b00, 16'hA5C3, 4'd0, 16'hA5C3);
        run_directed("cnt0_sra", 2'b10, 16'hA5C3, 4'd0, 16'hA5C3);
        run_directed("rol_wrap", 2'b00, 16'h1234, 4'd12, 16'h4123);

        // Backpressure in DONE, then back-to-back accept on release.
        in_valid = 1'b1; in_op = 2'b01; in_data = 16'h1234; in_cnt = 4'd3; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 16'h91A0);
            check("bp_in_ready", in_ready, 1'b0);
            tick;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1; in_op = 2'b11; in_data = 16'hF00F; in_cnt = 4'd5;
        #1;
        check("b2b_in_ready", in_ready, 1'b1);
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("b2b_early_valid", out_valid, 1'b0);
            tick;
        end
        check("b2b_early_valid", out_valid, 1'b0);
        tick;
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_data", out_data, 16'h0780);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of SHIFT step 2.
        in_valid = 1'b1; in_op = 2'b00; in_data = 16'h1234; in_cnt = 4'd7;
        tick;
        in_valid = 1'b0;
        repeat (2) tick;
        check("mid_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_out_data", out_data, 16'h0000);
        check("async_rst_busy", busy, 1'b0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            check("post_rst_out_valid", out_valid, 1'b0);
            check("post_rst_busy", busy, 1'b0);
        end

        // Randomized traffic against the reference model.
        cyc        = 0;
        acc_cyc    = 0;
        nreq       = 0;
        pending    = 1'b0;
        prev_valid = 1'b0;
        prev_hold  = 1'b0;
        exp_data   = '0;
        prev_data  = '0;
        while (nreq < 10000 && cyc < 80000) begin
            @(posedge clk);
            cyc++;
            #1;
            in_valid  = ($urandom_range(0, 7) != 0);
            in_op     = 2'($urandom);
            in_data   = 16'($urandom);
            in_cnt    = 4'($urandom);
            out_ready = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            if (out_valid) begin
                check("rnd_valid_has_request", pending, 1'b1);
                if (!prev_valid) check("rnd_latency", cyc - acc_cyc, 4);
            end
            if (prev_hold) check("rnd_held_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                check("rnd_data", out_data, exp_data);
                pending = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_data = ref_shift(in_op, in_data, in_cnt);
                pending  = 1'b1;
                acc_cyc  = cyc + 1;   // the accepting edge starts the next iteration
                nreq++;
            end
            prev_hold  = out_valid && !out_ready;
            prev_data  = out_data;
            prev_valid = out_valid;
        end
        check("rnd_request_count", nreq, 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
